// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between execute and a word-wide data memory.
// Splits word-crossing accesses into two beats, merges load data and extends it per funct3.
module lsu_mem_sequencer #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [2:0]        req_func3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              busy,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state, state_nx;

   // Accept-time decode, taken straight from the request inputs.
   logic [2:0]        in_size;
   logic [1:0]        in_off;
   logic [7:0]        in_mask8;
   logic              in_split;
   logic              in_illegal;
   logic [XLEN-1:0]   in_wd0;
   logic [XLEN-1:0]   in_wd1;
   logic [ADDR_W-1:0] in_addr0;
   logic [ADDR_W-1:0] in_addr1;

   always_comb begin
      in_off = req_addr[1:0];
      case (req_func3[1:0])
         2'b00:   in_size = 3'd1;
         2'b01:   in_size = 3'd2;
         default: in_size = 3'd4;
      endcase
      in_mask8 = ((8'd1 << in_size) - 8'd1) << in_off;
      in_split = ({1'b0, in_off} + in_size) > 3'd4;
      if (req_is_store)
         in_illegal = req_func3[2] | (req_func3[1:0] == 2'b11);
      else
         in_illegal = (req_func3 == 3'b011) | (req_func3[2:1] == 2'b11);
      in_wd0   = req_wdata << {in_off, 3'b000};
      in_wd1   = req_wdata >> (6'd32 - {1'b0, in_off, 3'b000});
      in_addr0 = {req_addr[ADDR_W-1:2], 2'b00};
      in_addr1 = in_addr0 + ADDR_W'(4);
   end

   // Second-beat geometry is precomputed at accept so BEAT1 only reloads registers.
   logic              st_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic              err_q;
   logic              split_q;
   logic [3:0]        be1_q;
   logic [XLEN-1:0]   wd1_q;
   logic [ADDR_W-1:0] addr1_q;
   logic [XLEN-1:0]   rdata0_q;
   logic [XLEN-9:0]   rdata1_q;

   logic accept;
   logic ld0, ld1, cap0, cap1, drop;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;
   assign busy      = (state != IDLE) | accept;

   // Handshake: a request is taken on an edge with req_valid & req_ready; a memory beat
   // completes on an edge with mem_req & mem_ack, and mem_* hold steady until then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ld0      = 1'b0;
      ld1      = 1'b0;
      cap0     = 1'b0;
      cap1     = 1'b0;
      drop     = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_nx = in_illegal ? RESP : BEAT0;
               ld0      = ~in_illegal;
            end
         end
         BEAT0: begin
            if (mem_ack) begin
               cap0 = 1'b1;
               if (split_q) begin
                  state_nx = BEAT1;
                  ld1      = 1'b1;
               end else begin
                  state_nx = RESP;
                  drop     = 1'b1;
               end
            end
         end
         BEAT1: begin
            if (mem_ack) begin
               cap1     = 1'b1;
               state_nx = RESP;
               drop     = 1'b1;
            end
         end
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q     <= 1'b0;
         f3_q     <= 3'd0;
         off_q    <= 2'd0;
         err_q    <= 1'b0;
         split_q  <= 1'b0;
         be1_q    <= 4'd0;
         wd1_q    <= '0;
         addr1_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (accept) begin
            st_q     <= req_is_store;
            f3_q     <= req_func3;
            off_q    <= in_off;
            err_q    <= in_illegal;
            split_q  <= in_split;
            be1_q    <= in_mask8[7:4];
            wd1_q    <= in_wd1;
            addr1_q  <= in_addr1;
            rdata0_q <= '0;
            rdata1_q <= '0;
         end
         if (cap0) rdata0_q <= mem_rdata;
         if (cap1) rdata1_q <= mem_rdata[XLEN-9:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'd0;
         mem_wdata <= '0;
      end else if (ld0) begin
         mem_req   <= 1'b1;
         mem_we    <= req_is_store;
         mem_addr  <= in_addr0;
         mem_be    <= in_mask8[3:0];
         mem_wdata <= in_wd0;
      end else if (ld1) begin
         mem_addr  <= addr1_q;
         mem_be    <= be1_q;
         mem_wdata <= wd1_q;
      end else if (drop) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'd0;
         mem_wdata <= '0;
      end
   end

   logic [XLEN-1:0] raw;
   logic [XLEN-1:0] ext;

   always_comb begin
      case (off_q)
         2'd0:    raw = rdata0_q;
         2'd1:    raw = {rdata1_q[7:0],  rdata0_q[31:8]};
         2'd2:    raw = {rdata1_q[15:0], rdata0_q[31:16]};
         default: raw = {rdata1_q[23:0], rdata0_q[31:24]};
      endcase
      case (f3_q)
         3'b000:  ext = {{24{raw[7]}},  raw[7:0]};
         3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
         3'b100:  ext = {24'd0, raw[7:0]};
         3'b101:  ext = {16'd0, raw[15:0]};
         default: ext = raw;
      endcase
   end

   assign resp_valid = (state == RESP);
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = (resp_valid & ~st_q & ~err_q) ? ext : '0;

endmodule
